// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: whack-a-mole round sequencer that lights a pseudo-random mole, judges switch toggles and keeps a saturating score.
// Optional build macro WAM_PENALTY_EN: a wrong-switch toggle while a mole is lit costs one point.
`timescale 1ns/1ps
module mole_round_ctrl #(
  parameter int unsigned MOLE_UP_TICKS = 1000,
  parameter int unsigned GAP_TICKS     = 250,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned MAX_SCORE     = 99
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        tick,
  input  logic        timer_expired,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [7:0]  score_count,
  output logic [2:0]  state,
  output logic        playing
);
  localparam int unsigned MAX_TICKS = (MOLE_UP_TICKS > GAP_TICKS) ? MOLE_UP_TICKS : GAP_TICKS;
  localparam int CW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
  localparam logic [CW-1:0] UP_LAST   = CW'(MOLE_UP_TICKS - 1);
  localparam logic [7:0]    SCORE_MAX = 8'(MAX_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_UP    = 3'd2,
    ST_JUDGE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [15:0]   lfsr_reg, lfsr_next;
  logic [15:0]   sw_q_reg;
  logic [3:0]    prev_idx_reg, prev_idx_next;
  logic          hit_reg, hit_next;
  logic [7:0]    score_reg, score_next;
  logic [15:0]   led_reg, led_next;
  logic          playing_reg, playing_next;

  logic [15:0]   toggle;
  logic          hit_now;
  logic [3:0]    base_idx, new_idx;

  // led_reg is exactly the one-hot mole while in UP, so it doubles as the hit mask
  assign toggle    = sw ^ sw_q_reg;
  assign hit_now   = |(toggle & led_reg);
  assign base_idx  = lfsr_reg[3:0];
  assign new_idx   = (base_idx == prev_idx_reg) ? base_idx + 4'd1 : base_idx;
  assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

`ifdef WAM_PENALTY_EN
  logic wrong_now;
  assign wrong_now = |(toggle & ~led_reg);
`endif

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    prev_idx_next = prev_idx_reg;
    hit_next      = hit_reg;
    score_next    = score_reg;
    led_next      = led_reg;
    unique case (state_reg)
      ST_IDLE, ST_OVER: begin
        if (start && !timer_expired) begin
          state_next = ST_GAP;
          score_next = '0;
          cnt_next   = '0;
        end
      end
      ST_GAP: begin
        if (timer_expired) begin
          state_next = ST_OVER;
        end else if (tick) begin
          if (cnt_reg == GAP_LAST) begin
            state_next    = ST_UP;
            cnt_next      = '0;
            prev_idx_next = new_idx;
            led_next      = 16'd1 << new_idx;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_UP: begin
        if (timer_expired) begin
          state_next = ST_OVER;
          led_next   = '0;
        end else if (hit_now) begin
          state_next = ST_JUDGE;
          hit_next   = 1'b1;
          led_next   = '0;
        end else begin
`ifdef WAM_PENALTY_EN
          if (wrong_now && score_reg != 8'd0) score_next = score_reg - 8'd1;
`endif
          if (tick) begin
            if (cnt_reg == UP_LAST) begin
              state_next = ST_JUDGE;
              hit_next   = 1'b0;
              led_next   = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
      end
      ST_JUDGE: begin
        // an expiring timer discards the pending hit
        if (timer_expired) begin
          state_next = ST_OVER;
        end else begin
          state_next = ST_GAP;
          cnt_next   = '0;
          if (hit_reg && score_reg < SCORE_MAX) score_next = score_reg + 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        led_next   = '0;
      end
    endcase
    playing_next = (state_next == ST_GAP) || (state_next == ST_UP) || (state_next == ST_JUDGE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      lfsr_reg     <= LFSR_SEED;
      sw_q_reg     <= '0;
      prev_idx_reg <= '0;
      hit_reg      <= 1'b0;
      score_reg    <= '0;
      led_reg      <= '0;
      playing_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      lfsr_reg     <= lfsr_next;
      sw_q_reg     <= sw;
      prev_idx_reg <= prev_idx_next;
      hit_reg      <= hit_next;
      score_reg    <= score_next;
      led_reg      <= led_next;
      playing_reg  <= playing_next;
    end
  end

  assign led         = led_reg;
  assign score_count = score_reg;
  assign state       = state_reg;
  assign playing     = playing_reg;
endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed testbench for mole_round_ctrl with GAP_TICKS=2, MOLE_UP_TICKS=4, MAX_SCORE=99.
`timescale 1ns/1ps
module tb_mole_round_ctrl;
  localparam int UP_T = 4;
  localparam int GAP_T = 2;
  localparam int MAXS = 99;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        tick = 1'b1;
  logic        timer_expired = 1'b0;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic [7:0]  score_count;
  logic [2:0]  state;
  logic        playing;

  int checks = 0;
  int errors = 0;
  int exp_score;
  int idx;
  int n;
  int prev;
  int repeats;
  logic [15:0] seen;
  logic [15:0] led_save;

  mole_round_ctrl #(
    .MOLE_UP_TICKS(UP_T),
    .GAP_TICKS(GAP_T),
    .LFSR_SEED(16'hACE1),
    .MAX_SCORE(MAXS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .tick(tick),
    .timer_expired(timer_expired),
    .sw(sw),
    .led(led),
    .score_count(score_count),
    .state(state),
    .playing(playing)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // waits (bounded) for a lit mole and returns its index
  task automatic wait_up(output int i);
    int k;
    k = 0;
    while (led === 16'h0 && k < 30) begin
      cyc();
      k++;
    end
    chk("wait_up_onehot", $countones(led), 1);
    chk("wait_up_state", state, 3'd2);
    i = 0;
    for (int b = 0; b < 16; b++) if (led[b]) i = b;
  endtask

  task automatic count_lit(output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (led !== 16'h0 && cnt < 20);
  endtask

  task automatic do_hit(input int d, output int i);
    wait_up(i);
    repeat (d) cyc();
    sw[i] = ~sw[i];
    cyc();
    cyc();
    if (exp_score < MAXS) exp_score++;
    chk("hit_score", score_count, exp_score);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values while reset is held low
    #22;
    chk("rst_state", state, 3'd0);
    chk("rst_led", led, 16'h0);
    chk("rst_score", score_count, 8'd0);
    chk("rst_playing", playing, 1'b0);
    reset = 1'b1;
    cyc();
    chk("idle_hold", state, 3'd0);

    // start: 2 dark ticks, then 4 lit ticks, miss
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("gap_state", state, 3'd1);
    chk("gap_led0", led, 16'h0);
    chk("gap_playing", playing, 1'b1);
    cyc();
    chk("gap_led1", led, 16'h0);
    cyc();
    chk("up_state", state, 3'd2);
    chk("up_onehot", $countones(led), 1);
    count_lit(n);
    chk("up_len_miss", n, UP_T);
    chk("miss_judge", state, 3'd3);
    cyc();
    chk("miss_gap", state, 3'd1);
    chk("miss_score", score_count, 8'd0);

    // hit latency
    exp_score = 0;
    wait_up(idx);
    sw[idx] = ~sw[idx];
    cyc();
    chk("hit_led_off", led, 16'h0);
    chk("hit_judge", state, 3'd3);
    chk("hit_score_n1", score_count, 8'd0);
    cyc();
    exp_score = 1;
    chk("hit_score_n2", score_count, 8'd1);
    chk("hit_to_gap", state, 3'd1);

    // held switch does not count again
    wait_up(idx);
    count_lit(n);
    chk("hold_len", n, UP_T);
    cyc();
    chk("hold_score", score_count, 8'd1);

    for (int h = 0; h < 4; h++) do_hit(h % 3, idx);
    chk("score5", score_count, 8'd5);

    // wrong-switch toggle
    wait_up(idx);
    led_save = led;
    sw[(idx + 1) % 16] = ~sw[(idx + 1) % 16];
    cyc();
`ifdef WAM_PENALTY_EN
    exp_score = exp_score - 1;
`endif
    chk("wrong_state", state, 3'd2);
    chk("wrong_led", led, led_save);
    chk("wrong_score", score_count, exp_score);

    // mole bit plus other bits in the same cycle: hit only
    sw[idx] = ~sw[idx];
    sw[(idx + 3) % 16] = ~sw[(idx + 3) % 16];
    cyc();
    chk("multi_judge", state, 3'd3);
    cyc();
    exp_score++;
    chk("multi_score", score_count, exp_score);

    // counter only advances on tick
    wait_up(idx);
    led_save = led;
    tick = 1'b0;
    repeat (10) cyc();
    chk("notick_led", led, led_save);
    chk("notick_state", state, 3'd2);
    tick = 1'b1;
    count_lit(n);
    chk("tick_len", n, UP_T);
    cyc();
    chk("tick_score", score_count, exp_score);

    // timer expiry overrides a same-cycle hit
    wait_up(idx);
    sw[idx] = ~sw[idx];
    timer_expired = 1'b1;
    cyc();
    chk("over_state", state, 3'd4);
    chk("over_led", led, 16'h0);
    chk("over_playing", playing, 1'b0);
    cyc();
    chk("over_score", score_count, exp_score);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("over_start_ignored", state, 3'd4);
    chk("over_score_hold", score_count, exp_score);
    timer_expired = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    exp_score = 0;
    chk("restart_state", state, 3'd1);
    chk("restart_score", score_count, 8'd0);
    chk("restart_playing", playing, 1'b1);

    // 200 moles, all hit: saturation, index spread, no back-to-back repeats
    prev = -1;
    repeats = 0;
    seen = '0;
    for (int m = 0; m < 200; m++) begin
      do_hit(m % 3, idx);
      if (idx == prev) repeats++;
      seen[idx] = 1'b1;
      prev = idx;
    end
    chk("no_repeat", repeats, 0);
    chk("all_indices", seen, 16'hFFFF);
    chk("sat_final", score_count, 8'd99);

    // asynchronous reset mid-UP
    wait_up(idx);
    reset = 1'b0;
    #1;
    chk("async_led", led, 16'h0);
    chk("async_score", score_count, 8'd0);
    chk("async_state", state, 3'd0);
    chk("async_playing", playing, 1'b0);
    #3;
    reset = 1'b1;
    cyc();
    chk("post_rst_idle", state, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
